oam_slave: RTL and testbench

- PPU-side receiver for the sprite-DMA write stream. Decodes CPU/DMA bus accesses to OAMADDR ($2003) and OAMDATA ($2004), holds the 256-byte OAM, and auto-increments the OAM address on each data write.
- Serves $2004 reads back to the CPU.
- Provides a read port for the renderer's sprite evaluation.
- Sits on the PPU register bus, downstream of the sprite DMA engine and the CPU.

---
 rtl/oam_pkg.sv | 16 +
 rtl/oam_ram.sv | 34 +++
 rtl/oam_slave.sv | 83 ++++++++
 tb/tb_oam_slave.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_pkg.sv
// Shared constants for the PPU OAM slave: register decode values, the
// attribute-byte read mask and the address step applied while rendering.
package oam_pkg;

  localparam logic [2:0] PPU_REG_WIN    = 3'b001;
  localparam logic [2:0] REG_OAMADDR    = 3'd3;
  localparam logic [2:0] REG_OAMDATA    = 3'd4;
  localparam logic [7:0] OAM_ATTR_MASK  = 8'hE3;
  localparam logic [7:0] OAM_RENDER_INC = 8'd4;

  // Byte 2 of each sprite is the attribute byte; bits 2-4 do not exist.
  function automatic logic [7:0] read_mask(input logic [1:0] byte_sel);
    return (byte_sel == 2'b10) ? OAM_ATTR_MASK : 8'hFF;
  endfunction

endpackage

// File: rtl/oam_ram.sv
// 256x8 simple dual-port OAM storage: port A writes and reads for the CPU/DMA
// side, port B reads for sprite evaluation. Reads return the pre-write byte.
module oam_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_we,
  input  logic          a_re,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic [7:0]    a_rdata,
  input  logic [AW-1:0] b_addr,
  output logic [7:0]    b_rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= 8'h00;
      b_rdata <= 8'h00;
    end else begin
      if (a_re) a_rdata <= mem[a_addr];
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/oam_slave.sv
// PPU-side OAM register slave: decodes $2003/$2004 (all mirrors), owns OAMADDR
// with auto-increment, serves masked $2004 reads and the sprite-eval read port.
module oam_slave
  import oam_pkg::*;
#(
  parameter logic [15:0] PPU_REG_BASE = {PPU_REG_WIN, 13'h0000},
  parameter int          OAM_AW       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       address_in,
  input  logic [7:0]        data_in,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rendering,
  input  logic              oamaddr_clear,
  input  logic [OAM_AW-1:0] eval_addr,
  output logic [7:0]        data_out,
  output logic [7:0]        eval_data,
  output logic [OAM_AW-1:0] oam_addr
);

  // Bus strobes are single-cycle qualifiers with no back-pressure: an access
  // is accepted on the clk edge where its strobe is high; a write strobe
  // suppresses any read strobe in the same cycle.
  logic       sel;
  logic [2:0] reg_idx;
  logic       wr_addr_hit;
  logic       wr_data_hit;
  logic       rd_data_hit;
  logic       ram_we;
  logic [7:0] ram_rdata;
  logic [7:0] rd_mask;
  logic       unused_addr_bits;

  assign sel         = (address_in[15:13] == PPU_REG_BASE[15:13]);
  assign reg_idx     = address_in[2:0];
  assign wr_addr_hit = sel && wr_en && (reg_idx == REG_OAMADDR);
  assign wr_data_hit = sel && wr_en && (reg_idx == REG_OAMDATA);
  assign rd_data_hit = sel && rd_en && !wr_en && (reg_idx == REG_OAMDATA);
  assign unused_addr_bits = ^address_in[12:3];

  // Writes during rendering are dropped; reset also drops an in-flight write.
  assign ram_we = wr_data_hit && !rendering && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oam_addr <= '0;
    end else if (oamaddr_clear) begin
      oam_addr <= '0;
    end else if (wr_addr_hit) begin
      oam_addr <= data_in[OAM_AW-1:0];
    end else if (wr_data_hit) begin
      oam_addr <= oam_addr + OAM_AW'(rendering ? OAM_RENDER_INC : 8'd1);
    end
  end

  // The mask is captured with the read so data_out stays stable until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_mask <= 8'hFF;
    end else if (rd_data_hit) begin
      rd_mask <= read_mask(oam_addr[1:0]);
    end
  end

  assign data_out = ram_rdata & rd_mask;

  oam_ram #(
    .AW(OAM_AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_we    (ram_we),
    .a_re    (rd_data_hit),
    .a_addr  (oam_addr),
    .a_wdata (data_in),
    .a_rdata (ram_rdata),
    .b_addr  (eval_addr),
    .b_rdata (eval_data)
  );

endmodule

// File: tb/tb_oam_slave.sv
// Directed bench for oam_slave: a byte-array model of OAM and OAMADDR is
// updated per bus cycle and compared every cycle, plus literal expectations.
module tb_oam_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address_in;
  logic [7:0]  data_in;
  logic        wr_en;
  logic        rd_en;
  logic        rendering;
  logic        oamaddr_clear;
  logic [7:0]  eval_addr;
  logic [7:0]  data_out;
  logic [7:0]  eval_data;
  logic [7:0]  oam_addr;

  always #5 clk = ~clk;

  oam_slave dut (
    .clk           (clk),
    .rst           (rst),
    .address_in    (address_in),
    .data_in       (data_in),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .rendering     (rendering),
    .oamaddr_clear (oamaddr_clear),
    .eval_addr     (eval_addr),
    .data_out      (data_out),
    .eval_data     (eval_data),
    .oam_addr      (oam_addr)
  );

  // Model state: X means "not yet known", which skips the comparison.
  logic [7:0] mem_m [256];
  logic [7:0] addr_m;
  logic [7:0] data_m;
  logic [7:0] eval_m;
  logic [7:0] cur_ea;

  int checks = 0;
  int errors = 0;

  int         lit_seq  = 0;
  int         lit_done = 0;
  int         lit_sel;
  logic [7:0] lit_exp;
  logic [7:0] lit_act;
  string      lit_name;

  // Compare process: model checks every cycle out of reset, literals on request.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (oam_addr !== addr_m) begin
        errors++;
        $display("FAIL model_oam_addr t=%0t got %h expected %h", $time, oam_addr, addr_m);
      end
      if (!$isunknown(data_m)) begin
        checks++;
        if (data_out !== data_m) begin
          errors++;
          $display("FAIL model_data_out t=%0t got %h expected %h", $time, data_out, data_m);
        end
      end
      if (!$isunknown(eval_m)) begin
        checks++;
        if (eval_data !== eval_m) begin
          errors++;
          $display("FAIL model_eval_data t=%0t got %h expected %h", $time, eval_data, eval_m);
        end
      end
    end
    if (lit_seq != lit_done) begin
      lit_act = (lit_sel == 0) ? oam_addr : (lit_sel == 1) ? data_out : eval_data;
      checks++;
      if (lit_act !== lit_exp) begin
        errors++;
        $display("FAIL %s t=%0t got %h expected %h", lit_name, $time, lit_act, lit_exp);
      end
      lit_done = lit_seq;
    end
  end

  // One bus cycle; the model applies the register rules to the same inputs.
  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w,
                      input logic r, input logic c, input logic [7:0] ea);
    int         na;
    logic       s;
    logic [2:0] idx;
    address_in    = a;
    data_in       = d;
    wr_en         = w;
    rd_en         = r;
    oamaddr_clear = c;
    eval_addr     = ea;
    cur_ea        = ea;
    @(posedge clk);
    if (rst) begin
      addr_m = 8'h00;
      data_m = 8'h00;
      eval_m = 8'h00;
    end else begin
      s   = (a[15:13] == 3'b001);
      idx = a[2:0];
      eval_m = mem_m[ea];
      if (s && r && !w && idx == 3'd4)
        data_m = (addr_m % 4 == 2) ? (mem_m[addr_m] & 8'hE3) : mem_m[addr_m];
      na = int'(addr_m);
      if (s && w && idx == 3'd4) begin
        if (!rendering) mem_m[addr_m] = d;
        na = (int'(addr_m) + (rendering ? 4 : 1)) % 256;
      end
      if (s && w && idx == 3'd3) na = int'(d);
      if (c) na = 0;
      addr_m = 8'(na);
    end
    #1;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    oamaddr_clear = 1'b0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    step(a, d, 1'b1, 1'b0, 1'b0, cur_ea);
  endtask

  task automatic bus_rd(input logic [15:0] a);
    step(a, 8'h00, 1'b0, 1'b1, 1'b0, cur_ea);
  endtask

  task automatic idle();
    step(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, cur_ea);
  endtask

  task automatic set_eval(input logic [7:0] ea);
    step(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, ea);
  endtask

  // sel: 0 = oam_addr, 1 = data_out, 2 = eval_data
  task automatic lit(input int sel, input logic [7:0] exp, input string name);
    lit_sel  = sel;
    lit_exp  = exp;
    lit_name = name;
    lit_seq++;
    @(negedge clk);
    #1;
    idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 8'hxx;
    addr_m = 8'h00; data_m = 8'h00; eval_m = 8'h00; cur_ea = 8'h00;
    rst = 1'b1; address_in = 16'h0000; data_in = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
    rendering = 1'b0; oamaddr_clear = 1'b0; eval_addr = 8'h00;

    lit(0, 8'h00, "reset_oam_addr");
    lit(1, 8'h00, "reset_data_out");
    lit(2, 8'h00, "reset_eval_data");
    rst = 1'b0;

    // DMA fill: 256 writes from address 0 wrap back to 0
    bus_wr(16'h2003, 8'h00);
    for (int i = 0; i < 256; i++) bus_wr(16'h2004, 8'(i) ^ 8'h55);
    lit(0, 8'h00, "dma_wrap_addr");
    set_eval(8'h00); lit(2, 8'h55, "eval_00");
    set_eval(8'h01); lit(2, 8'h54, "eval_01");
    set_eval(8'h02); lit(2, 8'h57, "eval_02_unmasked");
    set_eval(8'hFF); lit(2, 8'hAA, "eval_ff");

    // Address wrap across FF
    bus_wr(16'h2003, 8'hFE);
    bus_wr(16'h2004, 8'h11);
    bus_wr(16'h2004, 8'h22);
    bus_wr(16'h2004, 8'h33);
    lit(0, 8'h01, "wrap_addr");
    set_eval(8'hFE); lit(2, 8'h11, "wrap_fe");
    set_eval(8'hFF); lit(2, 8'h22, "wrap_ff");
    set_eval(8'h00); lit(2, 8'h33, "wrap_00");

    // Attribute-byte masking on $2004 reads
    bus_wr(16'h2003, 8'h02);
    bus_wr(16'h2004, 8'hFF);
    bus_wr(16'h2003, 8'h02);
    bus_rd(16'h2004);
    lit(1, 8'hE3, "attr_masked_read");
    lit(0, 8'h02, "read_keeps_addr");
    bus_wr(16'h2003, 8'h03);
    bus_rd(16'h2004);
    lit(1, 8'h56, "raw_read_03");

    // Mirror decode and out-of-window access
    bus_wr(16'h3FF3, 8'h40);
    lit(0, 8'h40, "mirror_oamaddr");
    bus_wr(16'h4014, 8'h99);
    bus_wr(16'h2000, 8'h12);
    bus_rd(16'h2002);
    lit(0, 8'h40, "ignored_writes");
    lit(1, 8'h56, "ignored_read_holds");

    // Writes during rendering: data dropped, address steps by 4
    rendering = 1'b1;
    bus_wr(16'h2003, 8'h10);
    bus_wr(16'h2004, 8'h99);
    rendering = 1'b0;
    lit(0, 8'h14, "render_inc4");
    set_eval(8'h10); lit(2, 8'h45, "render_no_write");

    // Reset in the middle of a DMA burst
    bus_wr(16'h2003, 8'h00);
    for (int i = 0; i < 128; i++) bus_wr(16'h2004, 8'(i) ^ 8'h55);
    lit(0, 8'h80, "mid_dma_addr");
    rst = 1'b1;
    addr_m = 8'h00; data_m = 8'h00; eval_m = 8'h00;
    lit(0, 8'h00, "mid_dma_rst_addr");
    lit(1, 8'h00, "mid_dma_rst_data");
    rst = 1'b0;
    bus_wr(16'h2004, 8'h77);
    lit(0, 8'h01, "post_rst_addr");
    set_eval(8'h00); lit(2, 8'h77, "post_rst_store");

    // oamaddr_clear wins the address but the write stores at the old address
    bus_wr(16'h2003, 8'h20);
    step(16'h2004, 8'hAB, 1'b1, 1'b0, 1'b1, cur_ea);
    lit(0, 8'h00, "clear_addr");
    set_eval(8'h20); lit(2, 8'hAB, "clear_store");

    // Simultaneous write and read: read ignored
    bus_wr(16'h2003, 8'h31);
    bus_rd(16'h2004);
    lit(1, 8'h64, "read_31");
    bus_wr(16'h2003, 8'h30);
    step(16'h2004, 8'h5A, 1'b1, 1'b1, 1'b0, cur_ea);
    lit(1, 8'h64, "wr_rd_data_holds");
    lit(0, 8'h31, "wr_rd_addr");
    set_eval(8'h30); lit(2, 8'h5A, "wr_rd_store");

    // Eval read-before-write on a same-address collision
    bus_wr(16'h2003, 8'h50);
    step(16'h2004, 8'hC3, 1'b1, 1'b0, 1'b0, 8'h50);
    lit(2, 8'h05, "eval_rbw_old");
    set_eval(8'h50); lit(2, 8'hC3, "eval_rbw_new");

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
